// File: rtl/host_wb_master_bridge.sv
// Executes decoded host commands (ping/write/read/reset) as single-beat Wishbone
// classic cycles with an auto-incrementing address, returning responses to the host side.
module host_wb_master_bridge #(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        master_ready,
    input  logic        ih_ready,
    input  logic        ih_reset,
    input  logic [31:0] in_command,
    input  logic [31:0] in_address,
    input  logic [27:0] in_data_count,
    input  logic [31:0] in_data,
    input  logic        oh_ready,
    output logic        oh_en,
    output logic [31:0] out_status,
    output logic [31:0] out_address,
    output logic [27:0] out_data_count,
    output logic [31:0] out_data,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i
);
    typedef enum logic [2:0] {
        IDLE, WB_WRITE, WB_READ, WR_WAIT_DATA, RD_PRESENT, RESPOND
    } state_t;

    // Counter runs 0..TIMEOUT_CYCLES-1 while the strobe is up, so the access lasts
    // at most TIMEOUT_CYCLES cycles.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_reg;
    logic [3:0]  opcode_reg;
    logic [31:0] start_addr_reg;
    logic [31:0] addr_reg;
    logic [31:0] data_reg;
    logic [31:0] rd_data_reg;
    logic [27:0] total_reg;
    logic [27:0] remain_reg;
    logic        err_reg;
    logic        first_reg;
    logic [15:0] tmo_reg;
    logic [31:0] status_word;
    logic        accept;
    logic        unused_cmd_bits;

    assign status_word     = {26'h0, err_reg, 1'b0, ~opcode_reg};
    assign accept          = ih_ready && master_ready;
    assign unused_cmd_bits = ^in_command[31:4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            master_ready   <= 1'b0;
            oh_en          <= 1'b0;
            out_status     <= '0;
            out_address    <= '0;
            out_data_count <= '0;
            out_data       <= '0;
            wb_cyc_o       <= 1'b0;
            wb_stb_o       <= 1'b0;
            wb_we_o        <= 1'b0;
            wb_sel_o       <= '0;
            wb_adr_o       <= '0;
            wb_dat_o       <= '0;
            opcode_reg     <= '0;
            start_addr_reg <= '0;
            addr_reg       <= '0;
            data_reg       <= '0;
            rd_data_reg    <= '0;
            total_reg      <= '0;
            remain_reg     <= '0;
            err_reg        <= 1'b0;
            first_reg      <= 1'b0;
            tmo_reg        <= '0;
        end else begin
            oh_en <= 1'b0;
            if (ih_reset) begin
                wb_cyc_o     <= 1'b0;
                wb_stb_o     <= 1'b0;
                wb_we_o      <= 1'b0;
                wb_sel_o     <= '0;
                wb_adr_o     <= '0;
                wb_dat_o     <= '0;
                err_reg      <= 1'b0;
                remain_reg   <= '0;
                opcode_reg   <= 4'd3;
                master_ready <= 1'b0;
                state_reg    <= RESPOND;
            end else begin
                case (state_reg)
                    IDLE: begin
                        master_ready <= 1'b1;
                        if (accept && in_command[3:0] <= 4'd3) begin
                            opcode_reg     <= in_command[3:0];
                            start_addr_reg <= in_address;
                            addr_reg       <= in_address;
                            data_reg       <= in_data;
                            total_reg      <= (in_data_count == '0) ? 28'd1 : in_data_count;
                            remain_reg     <= (in_data_count == '0) ? 28'd1 : in_data_count;
                            err_reg        <= 1'b0;
                            first_reg      <= 1'b1;
                            master_ready   <= 1'b0;
                            case (in_command[1:0])
                                2'd1:    state_reg <= WB_WRITE;
                                2'd2:    state_reg <= WB_READ;
                                default: state_reg <= RESPOND;
                            endcase
                        end
                    end
                    WB_WRITE, WB_READ: begin
                        if (!wb_cyc_o) begin
                            wb_cyc_o <= 1'b1;
                            wb_stb_o <= 1'b1;
                            wb_we_o  <= (state_reg == WB_WRITE);
                            wb_sel_o <= 4'hF;
                            wb_adr_o <= addr_reg;
                            wb_dat_o <= (state_reg == WB_WRITE) ? data_reg : 32'h0;
                            tmo_reg  <= '0;
                        end else if (wb_ack_i || tmo_reg == TMO_LAST) begin
                            wb_cyc_o <= 1'b0;
                            wb_stb_o <= 1'b0;
                            wb_we_o  <= 1'b0;
                            wb_sel_o <= '0;
                            wb_adr_o <= '0;
                            wb_dat_o <= '0;
                            addr_reg <= addr_reg + 32'd1;
                            if (!wb_ack_i) begin
                                err_reg <= 1'b1;
                            end
                            if (state_reg == WB_WRITE) begin
                                remain_reg <= remain_reg - 28'd1;
                                if (remain_reg == 28'd1) begin
                                    state_reg <= RESPOND;
                                end else begin
                                    master_ready <= 1'b1;
                                    state_reg    <= WR_WAIT_DATA;
                                end
                            end else begin
                                rd_data_reg <= wb_ack_i ? wb_dat_i : 32'h0;
                                state_reg   <= RD_PRESENT;
                            end
                        end else begin
                            tmo_reg <= tmo_reg + 16'd1;
                        end
                    end
                    WR_WAIT_DATA: begin
                        if (accept) begin
                            data_reg     <= in_data;
                            master_ready <= 1'b0;
                            state_reg    <= WB_WRITE;
                        end
                    end
                    RD_PRESENT: begin
                        if (oh_ready) begin
                            oh_en    <= 1'b1;
                            out_data <= rd_data_reg;
                            // Only the first word carries the header fields.
                            if (first_reg) begin
                                out_status     <= status_word;
                                out_address    <= start_addr_reg;
                                out_data_count <= total_reg - 28'd1;
                                first_reg      <= 1'b0;
                            end
                            remain_reg <= remain_reg - 28'd1;
                            if (remain_reg == 28'd1) begin
                                err_reg      <= 1'b0;
                                master_ready <= 1'b1;
                                state_reg    <= IDLE;
                            end else begin
                                state_reg <= WB_READ;
                            end
                        end
                    end
                    RESPOND: begin
                        if (oh_ready) begin
                            oh_en          <= 1'b1;
                            out_status     <= status_word;
                            out_address    <= start_addr_reg;
                            out_data_count <= '0;
                            out_data       <= data_reg;
                            err_reg        <= 1'b0;
                            master_ready   <= 1'b1;
                            state_reg      <= IDLE;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end
endmodule
